// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, sticky error flags, thresholds.
// Latency: write-to-readable 1 cycle; standard read data 1 cycle after rd_acc (SYNC_FIFO_FWFT_EN: head shown combinationally).
// Backpressure: writes dropped when full unless a read is accepted the same cycle; overflow/underflow stick until clr_err.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH_C = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_TH_C = CW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc, rd_acc;

  // Flags decode only from registered count, so they never glitch mid-cycle.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= AE_TH_C);
  assign almost_full  = (count_q >= AF_TH_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    rd_acc      = rd_en && !empty;
    wr_acc      = wr_en && (!full || rd_acc);
    wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as clr_err keeps the flag set.
    overflow_d  = (overflow_q  && !clr_err) || (wr_en && !wr_acc);
    underflow_d = (underflow_q && !clr_err) || (rd_en && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; contents are unreachable after reset anyway.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out   = mem_q[rd_ptr_q];
  assign data_valid = !empty;
`else
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;

  always_comb begin
    data_out_d   = rd_acc ? mem_q[rd_ptr_q] : data_out_q;
    data_valid_d = rd_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at DATA_W=8, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] count;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;

  int total = 0;
  int bad   = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .clr_err(clr_err), .data_out(data_out), .data_valid(data_valid), .count(count),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and land 1ns after it, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin bad++; $display("FAIL reset_flags got=%b want=1100", {empty, almost_empty, full, almost_full}); end
    total++; if ({overflow, underflow, data_valid} !== 3'b000) begin bad++; $display("FAIL reset_err_vld got=%b want=000", {overflow, underflow, data_valid}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      data_in = 8'(8'h11 + i);
      tick();
      total++; if (count !== 4'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, i + 1); end
      total++; if (almost_full !== (i + 1 >= 6)) begin bad++; $display("FAIL fill_afull[%0d] got=%b", i, almost_full); end
      total++; if (full !== (i == 7)) begin bad++; $display("FAIL fill_full[%0d] got=%b", i, full); end
      total++; if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty[%0d] got=%b want=0", i, empty); end
      total++; if (almost_empty !== (i + 1 <= 2)) begin bad++; $display("FAIL fill_aempty[%0d] got=%b", i, almost_empty); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf[%0d] got=%b want=0", i, overflow); end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_overflow();
    wr_en = 1'b1;
    data_in = 8'hAA;
    tick();
    wr_en = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d want=8", count); end
    tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
  endtask

  task automatic test_read_all();
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL rd_vld[%0d] got=%b want=1", i, data_valid); end
      total++; if (data_out !== 8'(8'h11 + i)) begin bad++; $display("FAIL rd_data[%0d] got=%h want=%h", i, data_out, 8'(8'h11 + i)); end
      total++; if (count !== 4'(7 - i)) begin bad++; $display("FAIL rd_count[%0d] got=%0d want=%0d", i, count, 7 - i); end
    end
    rd_en = 1'b0;
    tick();
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rd_vld_drop got=%b want=0", data_valid); end
    total++; if (data_out !== 8'h18) begin bad++; $display("FAIL rd_hold got=%h want=18", data_out); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rd_empty got=%b want=1", empty); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL rd_unf_pre got=%b want=0", underflow); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_set got=%b want=1", underflow); end
    total++; if ({data_valid, count} !== 5'b0_0000) begin bad++; $display("FAIL unf_state got=%b want=00000", {data_valid, count}); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b want=0", underflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      data_in = 8'(8'h30 + i);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      data_in = 8'(8'h38 + i);
      tick();
      total++; if (count !== 4'd8) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=8", i, count); end
      total++; if ({data_valid, data_out} !== {1'b1, 8'(8'h30 + i)}) begin bad++; $display("FAIL b2b_data[%0d] got=%b/%h want=1/%h", i, data_valid, data_out, 8'(8'h30 + i)); end
      total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL b2b_err[%0d] got=%b want=00", i, {overflow, underflow}); end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      total++; if (data_out !== 8'(8'h44 + i)) begin bad++; $display("FAIL b2b_drain[%0d] got=%h want=%h", i, data_out, 8'(8'h44 + i)); end
    end
    rd_en = 1'b0;
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b want=1", empty); end
  endtask

  task automatic test_empty_simul();
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_in = 8'h77;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    total++; if (count !== 4'd1) begin bad++; $display("FAIL es_count got=%0d want=1", count); end
    total++; if ({underflow, data_valid} !== 2'b10) begin bad++; $display("FAIL es_unf_vld got=%b want=10", {underflow, data_valid}); end
    rd_en = 1'b1;
    clr_err = 1'b1;
    tick();
    rd_en = 1'b0;
    clr_err = 1'b0;
    total++; if ({data_valid, data_out} !== {1'b1, 8'h77}) begin bad++; $display("FAIL es_read got=%b/%h want=1/77", data_valid, data_out); end
    total++; if ({underflow, empty} !== 2'b01) begin bad++; $display("FAIL es_after got=%b want=01", {underflow, empty}); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      data_in = 8'(8'hC0 + i);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if ({data_valid, data_out, count} !== {1'b1, 8'hC0, 4'd2}) begin bad++; $display("FAIL ar_pre got=%b/%h/%0d want=1/c0/2", data_valid, data_out, count); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if ({count, empty, almost_empty, full, almost_full} !== 8'b0000_1100) begin bad++; $display("FAIL ar_now_flags got=%b want=00001100", {count, empty, almost_empty, full, almost_full}); end
    total++; if ({data_valid, data_out} !== 9'h000) begin bad++; $display("FAIL ar_now_data got=%b/%h want=0/00", data_valid, data_out); end
    tick();
    rst_n = 1'b1;
    tick();
    total++; if ({empty, count} !== 5'b1_0000) begin bad++; $display("FAIL ar_release got=%b want=10000", {empty, count}); end
  endtask

  task automatic test_fwft();
    wr_en = 1'b1;
    data_in = 8'h5C;
    tick();
    wr_en = 1'b0;
    total++; if ({data_valid, data_out} !== {1'b1, 8'h5C}) begin bad++; $display("FAIL fwft_head got=%b/%h want=1/5c", data_valid, data_out); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if ({empty, data_valid} !== 2'b10) begin bad++; $display("FAIL fwft_pop got=%b want=10", {empty, data_valid}); end
  endtask

  initial begin
    test_reset();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`else
    test_fill();
    test_overflow();
    test_read_all();
    test_back_to_back();
    test_empty_simul();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
